// File: rtl/mod_sampler_pkg.sv
// rtl/mod_sampler_pkg.sv - shared widths, FSM states and helpers for modulation_sampler
package mod_sampler_pkg;

  localparam int ADDR_W = 16;
  localparam int DIV_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // A divider of zero would never reach terminal count; treat it as one.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/delay_token_pipe.sv
// rtl/delay_token_pipe.sv - 1-bit token shift register for aligning with BRAM read latency
module delay_token_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (flush) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/modulation_sampler.sv
// rtl/modulation_sampler.sv - steps the modulation BRAM index at CLK/FREQ_DIV and captures amplitudes
module modulation_sampler #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = mod_sampler_pkg::ADDR_W,
  parameter int DIV_W       = mod_sampler_pkg::DIV_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              SYNC,
  input  logic [DIV_W-1:0]  FREQ_DIV,
  input  logic [ADDR_W-1:0] CYCLE,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        M_IN,
  output logic [7:0]        M,
  output logic              M_VALID
);

  import mod_sampler_pkg::*;

  state_e            state, state_n;
  logic [ADDR_W-1:0] addr_n, cycle_s, cycle_n;
  logic [DIV_W-1:0]  presc, presc_n, div_s, div_n;
  logic              fetch, fetch_n, flush, tok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    addr_n  = ADDR;
    presc_n = presc;
    div_n   = div_s;
    cycle_n = cycle_s;
    fetch_n = 1'b0;
    flush   = 1'b0;
    case (state)
      IDLE: begin
        addr_n  = '0;
        presc_n = '0;
        if (EN && SYNC) state_n = LOAD;
      end
      LOAD: begin
        addr_n  = '0;
        presc_n = '0;
        if (!EN) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else begin
          div_n   = clamp_div(FREQ_DIV);
          cycle_n = CYCLE;
          fetch_n = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!EN) begin
          addr_n  = '0;
          presc_n = '0;
          flush   = 1'b1;
          state_n = IDLE;
        end else if (SYNC) begin
          // Restart wins over a coincident terminal count; LOAD zeroes the index.
          state_n = LOAD;
        end else if (presc == div_s - DIV_W'(1)) begin
          presc_n = '0;
          fetch_n = 1'b1;
          if (ADDR == cycle_s) begin
            addr_n  = '0;
            div_n   = clamp_div(FREQ_DIV);
            cycle_n = CYCLE;
          end else begin
            addr_n = ADDR + ADDR_W'(1);
          end
        end else begin
          presc_n = presc + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // fetch marks the cycle the new index is on the bus, so the pipe output
  // lines up with M_IN arriving MEM_LATENCY cycles later.
  delay_token_pipe #(.DEPTH(MEM_LATENCY)) u_pipe (
    .clk   (CLK),
    .rst_n (RST_N),
    .flush (flush),
    .din   (fetch),
    .dout  (tok)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ADDR    <= '0;
      presc   <= '0;
      div_s   <= DIV_W'(1);
      cycle_s <= '0;
      fetch   <= 1'b0;
      M       <= '0;
      M_VALID <= 1'b0;
    end else begin
      ADDR    <= addr_n;
      presc   <= presc_n;
      div_s   <= div_n;
      cycle_s <= cycle_n;
      fetch   <= fetch_n;
      M_VALID <= tok && !flush;
      if (tok && !flush) M <= M_IN;
    end
  end

endmodule

// File: tb/tb_modulation_sampler.sv
// tb/tb_modulation_sampler.sv - scoreboard bench for modulation_sampler
module tb_modulation_sampler;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b0;
  logic        SYNC = 1'b0;
  logic [31:0] FREQ_DIV = 32'd0;
  logic [15:0] CYCLE = 16'd0;
  logic [15:0] ADDR;
  logic [7:0]  M_IN = 8'd0;
  logic [7:0]  M;
  logic        M_VALID;

  modulation_sampler #(.MEM_LATENCY(2), .ADDR_W(16), .DIV_W(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .EN       (EN),
    .SYNC     (SYNC),
    .FREQ_DIV (FREQ_DIV),
    .CYCLE    (CYCLE),
    .ADDR     (ADDR),
    .M_IN     (M_IN),
    .M        (M),
    .M_VALID  (M_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         npass = 0;
  int         ntotal = 0;
  logic [7:0] seed = 8'd0;
  logic [7:0] d1 = 8'd0;

  bit active = 1'b0;
  int load_at = -1;
  int next_change = 0;
  int idx = 0;
  int mdiv = 1;
  int mcyc = 0;
  int exp_addr = 0;

  function automatic logic [7:0] dat(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (lo * 8'd29) ^ a[15:8] ^ seed;
  endfunction

  // Two-cycle registered read port.
  always @(posedge CLK) begin
    d1   <= dat(ADDR);
    M_IN <= d1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic take_settings();
    mdiv = (FREQ_DIV == 32'd0) ? 1 : int'(FREQ_DIV);
    mcyc = int'(CYCLE);
  endtask

  task automatic emit();
    exp_t e;
    exp_addr = idx;
    e.due  = cyc + 3;
    e.data = dat(16'(idx));
    sbq.push_back(e);
  endtask

  // Reference model: a pattern entry is visited every mdiv edges; settings
  // are taken whenever the pattern (re)enters index 0.
  always @(posedge CLK) begin
    cyc++;
    if (!RST_N) begin
      active = 1'b0; load_at = -1; exp_addr = 0;
      sbq.delete();
    end else if ((active || load_at >= 0) && !EN) begin
      while (sbq.size() > 0 && sbq[$].due >= cyc) sbq.delete(sbq.size() - 1);
      active = 1'b0; load_at = -1; exp_addr = 0;
    end else if (load_at == cyc) begin
      load_at = -1; active = 1'b1; idx = 0;
      take_settings();
      emit();
      next_change = cyc + mdiv;
    end else if (EN && SYNC) begin
      load_at = cyc + 1;
      active = 1'b0;
    end else if (active && cyc == next_change) begin
      idx = (idx == mcyc) ? 0 : idx + 1;
      if (idx == 0) take_settings();
      emit();
      next_change = cyc + mdiv;
    end
  end

  // Monitor
  always @(negedge CLK) begin
    if (RST_N) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        ntotal++;
        $display("FAIL missing_mvalid: no strobe at cycle %0d, expected M=%0h", sbq[0].due, sbq[0].data);
        sbq.delete(0);
      end
      chk("addr", 32'(ADDR), 32'(exp_addr));
      if (M_VALID) begin
        if (sbq.size() == 0) begin
          ntotal++;
          $display("FAIL unexpected_mvalid: M_VALID=1 M=%0h at cycle %0d, expected no strobe", M, cyc);
        end else begin
          chk("mvalid_cycle", 32'(cyc), 32'(sbq[0].due));
          chk("m_data", 32'(M), 32'(sbq[0].data));
          sbq.delete(0);
        end
      end
    end
  end

  task automatic pulse_sync(input logic [31:0] fd, input logic [15:0] cy);
    FREQ_DIV = fd; CYCLE = cy; EN = 1'b1; SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic wait_addr(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (exp_addr == target && ADDR == 16'(target)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      ntotal++;
      $display("FAIL wait_addr: ADDR=%0d never reached %0d within %0d cycles", ADDR, target, limit);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    seed = 8'($urandom);
    run(3);
    chk("reset_addr", 32'(ADDR), 32'd0);
    chk("reset_m", 32'(M), 32'd0);
    chk("reset_mvalid", 32'(M_VALID), 32'd0);
    RST_N = 1'b1;

    // Enabled but never synced: stays idle.
    EN = 1'b1; FREQ_DIV = 32'd3; CYCLE = 16'd5;
    run(100);
    chk("idle_m", 32'(M), 32'd0);
    chk("idle_addr", 32'(ADDR), 32'd0);

    pulse_sync(32'd4, 16'd2);
    run(40);

    pulse_sync(32'd0, 16'd3);
    run(30);

    // Mid-pattern CYCLE change takes effect only at the wrap.
    pulse_sync(32'd2, 16'd7);
    wait_addr(5, 40, ok);
    CYCLE = 16'd3;
    run(40);

    // SYNC on the terminal count at index 5.
    pulse_sync(32'd1, 16'd9);
    wait_addr(5, 40, ok);
    SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0;
    chk("sync_hold_addr", 32'(ADDR), 32'd5);
    @(negedge CLK);
    chk("sync_restart_addr", 32'(ADDR), 32'd0);
    run(20);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 37 == 0) begin
        FREQ_DIV = 32'($urandom_range(0, 4));
        CYCLE    = 16'($urandom_range(0, 6));
      end
      SYNC = ($urandom_range(0, 24) == 0);
      EN   = ($urandom_range(0, 149) != 0);
      @(negedge CLK);
    end
    SYNC = 1'b0; EN = 1'b1;
    run(20);

    // Asynchronous reset mid-run.
    pulse_sync(32'd2, 16'd15);
    wait_addr(9, 60, ok);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_addr", 32'(ADDR), 32'd0);
    chk("async_rst_m", 32'(M), 32'd0);
    chk("async_rst_mvalid", 32'(M_VALID), 32'd0);
    run(2);
    RST_N = 1'b1;
    run(30);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
